// File: rtl/laundry_scheduler.sv
// rtl/laundry_scheduler.sv - round-robin owner arbitration and stall watchdog for one shared washing machine
module laundry_scheduler #(
  parameter int NUM_USERS     = 4,
  parameter int START_TIMEOUT = 8,
  parameter int RUN_TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_USERS-1:0] req,
  input  logic                 supply,
  input  logic [2:0]           stage,
  input  logic                 clear_fault,
  output logic                 cycle,
  output logic [NUM_USERS-1:0] grant,
  output logic                 busy,
  output logic [NUM_USERS-1:0] done,
  output logic                 fault
);

  localparam int PW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

  // Machine stage codes as seen on the stage bus.
  localparam logic [2:0] MS_IDLE = 3'd0;
  localparam logic [2:0] MS_FILL = 3'd1;
  localparam logic [2:0] MS_DONE = 3'd5;

  localparam logic [15:0] START_LIM = 16'(START_TIMEOUT);
  localparam logic [15:0] RUN_LIM   = 16'(RUN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FINISH,
    S_FAULT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        ptr_next;
  logic [PW-1:0]        owner;
  logic [PW-1:0]        owner_next;
  logic [PW-1:0]        owner_wrap;
  logic [NUM_USERS-1:0] grant_next;
  logic [NUM_USERS-1:0] done_next;
  logic [15:0]          wdog;
  logic [15:0]          wdog_next;
  logic [15:0]          wdog_inc;
  logic                 found;
  logic [PW-1:0]        pick;
  int                   idx;

  // Watchdog increment saturates so a very long stall cannot wrap back to a small count.
  assign wdog_inc = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;

  // Next search start after a completed program: the user after the winner, wrapping.
  assign owner_wrap = (owner == PW'(NUM_USERS - 1)) ? '0 : owner + 1'b1;

  // Round-robin search: first set request at or above ptr, wrapping to index 0.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int i = 0; i < NUM_USERS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_USERS) idx = idx - NUM_USERS;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Next-state logic: arbitration, program tracking, watchdog and fault handling.
  always_comb begin
    state_next = state;
    grant_next = grant;
    done_next  = '0;
    ptr_next   = ptr;
    owner_next = owner;
    wdog_next  = wdog;
    case (state)
      S_IDLE: begin
        if (supply && found && stage == MS_IDLE) begin
          grant_next = NUM_USERS'(1) << pick;
          owner_next = pick;
          wdog_next  = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (stage == MS_FILL) begin
          wdog_next  = '0;
          state_next = S_RUN;
        end else if (supply) begin
          wdog_next = wdog_inc;
          if (wdog_inc >= START_LIM) begin
            grant_next = '0;
            state_next = S_FAULT;
          end
        end
      end
      S_RUN: begin
        // IDLE or an undefined code mid-program means the machine lost its place.
        if (stage == MS_IDLE || stage > MS_DONE) begin
          grant_next = '0;
          state_next = S_FAULT;
        end else if (stage == MS_DONE) begin
          state_next = S_FINISH;
        end else if (supply) begin
          wdog_next = wdog_inc;
          if (wdog_inc >= RUN_LIM) begin
            grant_next = '0;
            state_next = S_FAULT;
          end
        end
      end
      S_FINISH: begin
        if (stage == MS_IDLE) begin
          done_next  = grant;
          grant_next = '0;
          ptr_next   = owner_wrap;
          state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        // ptr is left alone so the faulted user is offered the machine first.
        grant_next = '0;
        if (clear_fault && stage == MS_IDLE) state_next = S_IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, including the search pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= '0;
      done  <= '0;
      ptr   <= '0;
      owner <= '0;
      wdog  <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      done  <= done_next;
      ptr   <= ptr_next;
      owner <= owner_next;
      wdog  <= wdog_next;
    end
  end

  // Start request follows supply only while waiting for the machine to leave IDLE.
  assign cycle = (state == S_START) && supply;
  assign busy  = (state == S_START) || (state == S_RUN) || (state == S_FINISH);
  assign fault = (state == S_FAULT);

endmodule
